// File: rtl/hpdl1414_driver.sv
`timescale 1ns/1ps
// HPDL-1414 driver: a host-writable character buffer with a dirty bit per digit.
// Each qualifying digit goes out on the shared bus in one SETUP/STROBE/HOLD write.
//
// state  | meaning
// IDLE   | pointer p scans for a qualifying digit, one digit per cycle
// SETUP  | address/data latched and stable, all WR_N high
// STROBE | WR_N low for the device that owns digit p
// HOLD   | WR_N high again, address/data still held
module hpdl1414_driver #(
  parameter int N_DISP      = 4,
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 1,
  parameter int REFRESH_ALL = 0,
  localparam int ND = 4 * N_DISP,
  localparam int AW = ($clog2(ND) < 2) ? 2 : $clog2(ND)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [6:0]        host_data,
  output logic [6:0]        HPDL_D,
  output logic [1:0]        HPDL_A,
  output logic [N_DISP-1:0] HPDL_WR_N,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = 16;
  localparam int ND_M1 = ND - 1;
  localparam logic [AW:0]   ND_EXT   = ND[AW:0];
  localparam logic [AW-1:0] P_LAST   = ND_M1[AW-1:0];
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] p;
  logic [AW-1:0] p_next;
  logic [AW-1:0] sel;
  logic [CW-1:0] cnt;
  logic [6:0]    char_buf [ND];
  logic [ND-1:0] dirty;
  logic          start;
  logic          cnt_done;
  logic          host_hit;

  // sel is the digit that enters SETUP on this edge: p from IDLE, or the
  // following digit when refresh mode chains HOLD straight into SETUP.
  always_comb begin
    p_next   = (p == P_LAST) ? '0 : p + 1'b1;
    cnt_done = (cnt == '0);
    host_hit = host_we && ({1'b0, host_addr} < ND_EXT);
    start    = 1'b0;
    sel      = p;
    if (state == IDLE) begin
      start = (REFRESH_ALL != 0) || dirty[p];
    end else if (state == HOLD && cnt_done && REFRESH_ALL != 0) begin
      start = 1'b1;
      sel   = p_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      p          <= '0;
      cnt        <= '0;
      HPDL_D     <= '0;
      HPDL_A     <= '0;
      HPDL_WR_N  <= '1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dirty      <= '1;
      for (int i = 0; i < ND; i++) char_buf[i] <= 7'h20;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!start) p <= p_next;
        end
        SETUP: begin
          if (cnt_done) begin
            state     <= STROBE;
            cnt       <= PULSE_LD;
            HPDL_WR_N <= ~(N_DISP'(1) << (p >> 2));
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_done) begin
            state     <= HOLD;
            cnt       <= HOLD_LD;
            HPDL_WR_N <= '1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            p          <= p_next;
            frame_done <= (p == P_LAST);
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        state      <= SETUP;
        cnt        <= SETUP_LD;
        HPDL_D     <= char_buf[sel];
        HPDL_A     <= ~sel[1:0];
        dirty[sel] <= 1'b0;
        busy       <= 1'b1;
      end

      // Placed last so a host write beats the SETUP-entry clear of the same digit.
      if (host_hit) begin
        char_buf[host_addr] <= host_data;
        dirty[host_addr]    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hpdl1414_driver.sv
`timescale 1ns/1ps
// Bench for hpdl1414_driver: three instances (12-digit dirty mode, 4-digit
// dirty mode, 8-digit refresh mode) watched by a bus monitor and a write-level model.
module tb_hpdl1414_driver;

  typedef struct packed {
    logic [3:0] dev;
    logic [1:0] a;
    logic [6:0] d;
  } rec_t;

  localparam int ND_K  [3] = '{12, 4, 8};
  localparam bit REF_K [3] = '{1'b0, 1'b0, 1'b1};
  localparam int SETUP = 1, PULSE = 2, HOLD = 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic       host_we;
  logic [3:0] host_addr;
  logic [6:0] host_data;
  logic       z_we;
  logic [1:0] z_a1;
  logic [2:0] z_ar;
  logic [6:0] z_d;

  logic [6:0] d_m, d_1, d_r;
  logic [1:0] a_m, a_1, a_r;
  logic [2:0] wr_m;
  logic       wr_1;
  logic [1:0] wr_r;
  logic       busy_m, busy_1, busy_r, fd_m, fd_1, fd_r;

  hpdl1414_driver #(.N_DISP(3)) dut_m (
    .CLK(CLK), .RST_N(RST_N), .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .HPDL_D(d_m), .HPDL_A(a_m), .HPDL_WR_N(wr_m), .busy(busy_m), .frame_done(fd_m));

  hpdl1414_driver #(.N_DISP(1)) dut_1 (
    .CLK(CLK), .RST_N(RST_N), .host_we(z_we), .host_addr(z_a1), .host_data(z_d),
    .HPDL_D(d_1), .HPDL_A(a_1), .HPDL_WR_N(wr_1), .busy(busy_1), .frame_done(fd_1));

  hpdl1414_driver #(.N_DISP(2), .REFRESH_ALL(1)) dut_r (
    .CLK(CLK), .RST_N(RST_N), .host_we(z_we), .host_addr(z_ar), .host_data(z_d),
    .HPDL_D(d_r), .HPDL_A(a_r), .HPDL_WR_N(wr_r), .busy(busy_r), .frame_done(fd_r));

  logic [7:0] wr_all   [3];
  logic [6:0] d_all    [3];
  logic [1:0] a_all    [3];
  logic       busy_all [3];
  logic       fd_all   [3];
  assign wr_all[0] = {5'h1f, wr_m};
  assign wr_all[1] = {7'h7f, wr_1};
  assign wr_all[2] = {6'h3f, wr_r};
  assign d_all[0] = d_m;  assign d_all[1] = d_1;  assign d_all[2] = d_r;
  assign a_all[0] = a_m;  assign a_all[1] = a_1;  assign a_all[2] = a_r;
  assign busy_all[0] = busy_m;  assign busy_all[1] = busy_1;  assign busy_all[2] = busy_r;
  assign fd_all[0] = fd_m;  assign fd_all[1] = fd_1;  assign fd_all[2] = fd_r;

  int vectors = 0;
  int errors  = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Completed writes seen on the bus, in order, for the two dirty-mode instances.
  rec_t qm[$];
  rec_t q1[$];

  int         cyc = 0;
  int         low_cnt [3], busy_run [3], since_push [3], last_fd [3], nxt [3], fd_cnt [3], last_idx [3];
  int         cdev [3];
  logic [6:0] cd [3], pd [3];
  logic [1:0] ca [3], pa [3];
  logic       prev_busy [3], prev_fd [3];
  int         m_nlow, m_dev, m_idx;

  initial begin
    for (int k = 0; k < 3; k++) begin
      fd_cnt[k] = 0; low_cnt[k] = 0; busy_run[k] = 0; since_push[k] = 100;
      last_fd[k] = -1; nxt[k] = 0; last_idx[k] = -1; prev_busy[k] = 1'b0; prev_fd[k] = 1'b0;
    end
  end

  always @(negedge CLK) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!RST_N) begin
        low_cnt[k] = 0; busy_run[k] = 0; since_push[k] = 100; last_fd[k] = -1;
        nxt[k] = 0; last_idx[k] = -1; prev_busy[k] = 1'b0; prev_fd[k] = 1'b0;
      end else begin
        m_nlow = $countones(~wr_all[k]);
        m_dev  = 0;
        for (int j = 0; j < 8; j++) if (!wr_all[k][j]) m_dev = j;
        chk("one_wr_low", 32'(m_nlow <= 1), 32'd1);
        if (busy_all[k]) busy_run[k]++;
        else begin
          if (prev_busy[k] && !REF_K[k]) chk("busy_window", 32'(busy_run[k]), 32'(SETUP + PULSE + HOLD));
          busy_run[k] = 0;
        end
        if (busy_all[k] && prev_busy[k] && !REF_K[k])
          chk("bus_stable", 32'({d_all[k], a_all[k]}), 32'({pd[k], pa[k]}));
        if (m_nlow == 1) begin
          if (low_cnt[k] == 0) begin
            cdev[k] = m_dev; cd[k] = d_all[k]; ca[k] = a_all[k];
            if (!REF_K[k]) chk("setup_len", 32'(busy_run[k]), 32'(SETUP + 1));
          end else begin
            chk("strobe_stable", 32'({d_all[k], a_all[k], 4'(m_dev)}), 32'({cd[k], ca[k], 4'(cdev[k])}));
          end
          low_cnt[k]++;
        end else if (low_cnt[k] > 0) begin
          chk("pulse_len", 32'(low_cnt[k]), 32'(PULSE));
          m_idx = cdev[k] * 4 + 3 - int'(ca[k]);
          if (REF_K[k]) begin
            chk("refresh_order", 32'(m_idx), 32'(nxt[k]));
            chk("refresh_data", 32'(cd[k]), 32'h20);
            nxt[k] = (nxt[k] + 1) % ND_K[k];
          end else if (k == 0) qm.push_back('{dev: 4'(cdev[k]), a: ca[k], d: cd[k]});
          else q1.push_back('{dev: 4'(cdev[k]), a: ca[k], d: cd[k]});
          last_idx[k] = m_idx;
          low_cnt[k] = 0;
          since_push[k] = 0;
        end else if (since_push[k] < 100) since_push[k]++;
        if (fd_all[k]) begin
          chk("fd_width", 32'(prev_fd[k]), 32'd0);
          if (!REF_K[k]) begin
            chk("fd_timing", 32'(since_push[k]), 32'(HOLD));
            chk("fd_last_digit", 32'(last_idx[k]), 32'(ND_K[k] - 1));
          end else if (last_fd[k] >= 0) begin
            chk("fd_period", 32'(cyc - last_fd[k]), 32'(ND_K[k] * (SETUP + PULSE + HOLD)));
          end
          last_fd[k] = cyc;
          fd_cnt[k]++;
        end
        prev_busy[k] = busy_all[k];
        prev_fd[k]   = fd_all[k];
        pd[k] = d_all[k];
        pa[k] = a_all[k];
      end
    end
  end

  function automatic rec_t expect_rec(input int addr, input logic [6:0] data);
    rec_t e;
    e.dev = 4'(addr / 4);
    e.a   = 2'(3 - addr % 4);
    e.d   = data;
    return e;
  endfunction

  task automatic host_wr(input int addr, input logic [6:0] data);
    host_addr = 4'(addr);
    host_data = data;
    host_we   = 1'b1;
    @(negedge CLK);
    host_we   = 1'b0;
  endtask

  task automatic wait_fd(input int k, input int target, input int maxc);
    int n = 0;
    while (fd_cnt[k] < target && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_frame_done", 32'(fd_cnt[k] >= target), 32'd1);
  endtask

  task automatic wait_rec(output rec_t r);
    int n = 0;
    while (qm.size() == 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_write", 32'(qm.size() > 0), 32'd1);
    r = (qm.size() > 0) ? qm.pop_front() : '0;
  endtask

  task automatic wait_strobe(input int dev);
    int n = 0;
    while (wr_m[dev] !== 1'b0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_strobe", 32'(wr_m[dev]), 32'd0);
  endtask

  task automatic check_blank(input int k);
    rec_t r;
    chk("blank_count", 32'((k == 0) ? qm.size() : q1.size()), 32'(ND_K[k]));
    for (int i = 0; i < ND_K[k]; i++) begin
      if (k == 0 && qm.size() > 0) r = qm.pop_front();
      else if (k == 1 && q1.size() > 0) r = q1.pop_front();
      else r = '0;
      chk("blank_write", 32'(r), 32'(expect_rec(i, 7'h20)));
    end
  endtask

  initial begin
    rec_t r;
    int   addr;
    int   base0, base1;
    logic [6:0] data;

    host_we = 1'b0; host_addr = '0; host_data = '0;
    z_we = 1'b0; z_a1 = '0; z_ar = '0; z_d = '0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_wr_m", 32'(wr_m), 32'h7);
    chk("rst_d_m", 32'(d_m), 32'h0);
    chk("rst_a_m", 32'(a_m), 32'h0);
    chk("rst_busy_m", 32'(busy_m), 32'h0);
    chk("rst_fd_m", 32'(fd_m), 32'h0);
    chk("rst_wr_1", 32'(wr_1), 32'h1);
    chk("rst_wr_r", 32'(wr_r), 32'h3);

    // Blank-on-release sequence on both dirty-mode instances.
    RST_N = 1'b1;
    wait_fd(1, 1, 80);
    wait_fd(0, 1, 200);
    check_blank(0);
    check_blank(1);
    repeat (20) @(negedge CLK);
    chk("idle_quiet_m", 32'(qm.size()), 32'd0);
    chk("idle_quiet_1", 32'(q1.size()), 32'd0);
    chk("idle_busy_m", 32'(busy_m), 32'd0);
    chk("idle_wr_m", 32'(wr_m), 32'h7);

    host_wr(5, 7'h41);
    wait_rec(r);
    chk("write_addr5", 32'(r), 32'(expect_rec(5, 7'h41)));
    repeat (20) @(negedge CLK);
    chk("addr5_quiet", 32'(qm.size()), 32'd0);

    for (int it = 0; it < 20; it++) begin
      addr = int'($urandom_range(0, 11));
      data = 7'($urandom);
      host_wr(addr, data);
      wait_rec(r);
      chk("rand_write", 32'(r), 32'(expect_rec(addr, data)));
      repeat (18) @(negedge CLK);
      chk("rand_quiet", 32'(qm.size()), 32'd0);
    end

    // Out-of-range addresses must not mark anything dirty.
    host_wr(12, 7'($urandom));
    host_wr(int'($urandom_range(13, 15)), 7'($urandom));
    repeat (30) @(negedge CLK);
    chk("oob_quiet", 32'(qm.size()), 32'd0);
    chk("oob_busy", 32'(busy_m), 32'd0);

    // Host write to the digit being strobed: old value goes out, new one follows.
    host_wr(7, 7'h30);
    wait_strobe(1);
    host_wr(7, 7'h42);
    wait_rec(r);
    chk("hit_old_value", 32'(r), 32'(expect_rec(7, 7'h30)));
    wait_rec(r);
    chk("hit_rewrite", 32'(r), 32'(expect_rec(7, 7'h42)));
    repeat (20) @(negedge CLK);
    chk("hit_quiet", 32'(qm.size()), 32'd0);

    // Reset in the middle of a strobe.
    host_wr(2, 7'h55);
    wait_strobe(0);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_async_wr_m", 32'(wr_m), 32'h7);
    chk("rst_async_busy_m", 32'(busy_m), 32'd0);
    chk("rst_async_d_m", 32'(d_m), 32'h0);
    chk("rst_async_wr_r", 32'(wr_r), 32'h3);
    qm.delete();
    q1.delete();
    base0 = fd_cnt[0];
    base1 = fd_cnt[1];
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    wait_fd(1, base1 + 1, 80);
    wait_fd(0, base0 + 1, 200);
    check_blank(0);
    check_blank(1);
    repeat (40) @(negedge CLK);
    chk("refresh_frames", 32'(fd_cnt[2] >= 3), 32'd1);
    chk("refresh_busy", 32'(busy_r), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
